// File: rtl/pipe_rca_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipe_rca_adder                                                  |
// | Purpose  : STAGES-segment pipelined ripple-carry add/sub, valid/ready I/O. |
// |            Define PIPE_RCA_SAT_EN to add the sat input (clamped results).  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pipe_rca_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] x,
    input  logic [2*WIDTH-1:0] y,
    input  logic               cin,
    input  logic               sub,
`ifdef PIPE_RCA_SAT_EN
    input  logic               sat,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] s,
    output logic               cout,
    output logic               ovf
);
    localparam int DW  = 2 * WIDTH;
    localparam int SEG = DW / STAGES;

    logic w_adv;
    assign w_adv    = out_ready | ~out_valid;
    assign in_ready = w_adv;

    if (DW % STAGES != 0) begin : g_bad_stages
        $error("pipe_rca_adder: STAGES must divide 2*WIDTH");
    end

    // Stage k owns result segment k; each stage keeps only the operand bits still to be added.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int IW = DW - k * SEG;
        logic [IW-1:0]          w_ia;
        logic [IW-1:0]          w_ib;
        logic                   w_ic;
        logic                   w_iv;
        logic [(k+1)*SEG-1:0]   w_res;
        logic [SEG:0]           w_add;
`ifdef PIPE_RCA_SAT_EN
        logic                   w_isat;
`endif

        assign w_add = {1'b0, w_ia[SEG-1:0]} + {1'b0, w_ib[SEG-1:0]} + {{SEG{1'b0}}, w_ic};

        if (k == 0) begin : g_head
            assign w_ia  = x;
            assign w_ib  = sub ? ~y : y;
            assign w_ic  = sub | cin;
            assign w_iv  = in_valid;
            assign w_res = w_add[SEG-1:0];
`ifdef PIPE_RCA_SAT_EN
            assign w_isat = sat;
`endif
        end else begin : g_body
            assign w_ia  = g_stage[k-1].g_mid.r_a;
            assign w_ib  = g_stage[k-1].g_mid.r_b;
            assign w_ic  = g_stage[k-1].g_mid.r_c;
            assign w_iv  = g_stage[k-1].g_mid.r_v;
            assign w_res = {w_add[SEG-1:0], g_stage[k-1].g_mid.r_s};
`ifdef PIPE_RCA_SAT_EN
            assign w_isat = g_stage[k-1].g_mid.r_sat;
`endif
        end

        if (k < STAGES - 1) begin : g_mid
            logic [IW-SEG-1:0]    r_a;
            logic [IW-SEG-1:0]    r_b;
            logic [(k+1)*SEG-1:0] r_s;
            logic                 r_c;
            logic                 r_v;
`ifdef PIPE_RCA_SAT_EN
            logic                 r_sat;
`endif
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a   <= '0;
                    r_b   <= '0;
                    r_s   <= '0;
                    r_c   <= 1'b0;
                    r_v   <= 1'b0;
`ifdef PIPE_RCA_SAT_EN
                    r_sat <= 1'b0;
`endif
                end else if (w_adv) begin
                    r_a   <= w_ia[IW-1:SEG];
                    r_b   <= w_ib[IW-1:SEG];
                    r_s   <= w_res;
                    r_c   <= w_add[SEG];
                    r_v   <= w_iv;
`ifdef PIPE_RCA_SAT_EN
                    r_sat <= w_isat;
`endif
                end
            end
        end else begin : g_last
            logic          w_ovf;
            logic [DW-1:0] w_s;
            logic [DW-1:0] r_s;
            logic          r_c;
            logic          r_ovf;
            logic          r_v;

            // Carry into the MSB is recovered from the MSB sum bit: a ^ b ^ sum.
            assign w_ovf = w_add[SEG] ^ (w_ia[IW-1] ^ w_ib[IW-1] ^ w_add[SEG-1]);
`ifdef PIPE_RCA_SAT_EN
            assign w_s = (w_isat && w_ovf) ?
                         (w_ia[IW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}}) :
                         w_res;
`else
            assign w_s = w_res;
`endif
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s   <= '0;
                    r_c   <= 1'b0;
                    r_ovf <= 1'b0;
                    r_v   <= 1'b0;
                end else if (w_adv) begin
                    r_s   <= w_s;
                    r_c   <= w_add[SEG];
                    r_ovf <= w_ovf;
                    r_v   <= w_iv;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].g_last.r_v;
    assign s         = g_stage[STAGES-1].g_last.r_s;
    assign cout      = g_stage[STAGES-1].g_last.r_c;
    assign ovf       = g_stage[STAGES-1].g_last.r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pipe_rca_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pipe_rca_adder                                               |
// | Purpose  : Scoreboard bench for pipe_rca_adder (WIDTH=8, STAGES=4).        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_pipe_rca_adder;
    localparam int WIDTH  = 8;
    localparam int STAGES = 4;
    localparam int DW     = 2 * WIDTH;
`ifdef PIPE_RCA_SAT_EN
    localparam int N_OUT  = 19;
`else
    localparam int N_OUT  = 17;
`endif

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [DW-1:0] x         = '0;
    logic [DW-1:0] y         = '0;
    logic          cin       = 1'b0;
    logic          sub       = 1'b0;
    logic          sat       = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] s;
    logic          cout;
    logic          ovf;

    typedef struct {
        logic [DW-1:0] s;
        logic          c;
        logic          o;
        int            acc;
        bit            lat;
    } exp_t;

    exp_t sb[$];
    int   tests  = 0;
    int   fails  = 0;
    int   cyc    = 0;
    int   nout   = 0;
    bit   lat_en = 1'b1;

    pipe_rca_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .cin       (cin),
        .sub       (sub),
`ifdef PIPE_RCA_SAT_EN
        .sat       (sat),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic ci,
                        input logic sb_i, input logic st, input logic [DW-1:0] es,
                        input logic ec, input logic eo);
        int w;
        w = 0;
        @(negedge clk);
        x        = a;
        y        = b;
        cin      = ci;
        sub      = sb_i;
        sat      = st;
        in_valid = 1'b1;
        #1;
        while (!in_ready && w < 50) begin
            w++;
            @(negedge clk);
            #1;
        end
        if (!in_ready) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        sb.push_back('{s: es, c: ec, o: eo, acc: cyc, lat: lat_en});
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("drain_queue_empty", sb.size(), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: compares each consumed result against the oldest expectation.
    initial begin
        exp_t          e;
        bit            prev_stall;
        logic [DW-1:0] prev_s;
        logic          prev_c;
        logic          prev_o;
        prev_stall = 1'b0;
        prev_s     = '0;
        prev_c     = 1'b0;
        prev_o     = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid) begin
                if (prev_stall) begin
                    chk("stall_hold_s", {16'd0, s}, {16'd0, prev_s});
                    chk("stall_hold_cout", {31'd0, cout}, {31'd0, prev_c});
                    chk("stall_hold_ovf", {31'd0, ovf}, {31'd0, prev_o});
                end
                if (!out_ready) begin
                    chk("in_ready_low_in_stall", {31'd0, in_ready}, 32'd0);
                end else if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got s=0x%0h with no pending beat", s);
                end else begin
                    e = sb.pop_front();
                    nout++;
                    chk("sum", {16'd0, s}, {16'd0, e.s});
                    chk("cout", {31'd0, cout}, {31'd0, e.c});
                    chk("ovf", {31'd0, ovf}, {31'd0, e.o});
                    if (e.lat) chk("latency", cyc - e.acc, STAGES);
                end
            end
            prev_stall = rst_n && out_valid && !out_ready;
            prev_s     = s;
            prev_c     = cout;
            prev_o     = ovf;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_s", {16'd0, s}, 32'd0);
        chk("reset_cout", {31'd0, cout}, 32'd0);
        chk("reset_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Directed vectors: x, y, cin, sub, sat -> s, cout, ovf
        send(16'h1234, 16'h0FCD, 1'b1, 1'b0, 1'b0, 16'h2202, 1'b0, 1'b0);
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        send(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        send(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0);
        send(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        send(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0);
        send(16'h0010, 16'h0010, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
`ifdef PIPE_RCA_SAT_EN
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1);
        send(16'h8000, 16'hFFFF, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1);
`endif
        drain();

        // Back-pressure: 8 beats x=i, y=0x100*i with out_ready low for 4 cycles.
        lat_en = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(DW'(i), DW'(i * 256), 1'b0, 1'b0, 1'b0, DW'(i * 257), 1'b0, 1'b0);
                end
            end
            begin
                repeat (6) @(negedge clk);
                out_ready = 1'b0;
                repeat (4) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();
        chk("output_count", nout, N_OUT);

        // Reset while three beats are in flight: none of them may emerge.
        lat_en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            send(DW'(i), DW'(i), 1'b0, 1'b0, 1'b0, DW'(2 * i), 1'b0, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_reset_s", {16'd0, s}, 32'd0);
        chk("post_reset_cout", {31'd0, cout}, 32'd0);
        chk("post_reset_ovf", {31'd0, ovf}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk("no_output_after_reset", {31'd0, seen}, 32'd0);
        chk("output_count_final", nout, N_OUT);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_rca_adder.md
Name: pipe_rca_adder

Overview:
Pipelined, segmented ripple-carry adder/subtractor. It is the clocked successor to the combinational 2*WIDTH-bit RCA used in the PE accumulate path. The carry chain is split into STAGES registered segments, which raises fmax for wide accumulators. Operand and result flow uses a valid/ready handshake with full back-pressure, and the block adds subtract mode and signed-overflow detection.

Parameters:
WIDTH, 8, half operand width; the datapath is 2*WIDTH bits (matches PE product/accumulator width)
STAGES, 4, number of pipeline segments; must divide 2*WIDTH exactly (elaboration error otherwise); SEG = 2*WIDTH/STAGES

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  block accepts a beat this cycle
x  input  2*WIDTH  operand A
y  input  2*WIDTH  operand B
cin  input  1  carry-in (add mode only)
sub  input  1  0 = x+y+cin; 1 = x-y (x + ~y + 1, cin ignored)
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
s  output  2*WIDTH  sum/difference
cout  output  1  carry out of bit 2*WIDTH-1 (in subtract mode, 1 = no borrow)
ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset (async assert, sync-release usage assumed by top level): all stage valid bits, s, cout, ovf and out_valid clear to 0. Asserting reset mid-operation discards every in-flight beat. No result emerges after release until new inputs arrive.
- advance = out_ready | ~out_valid. in_ready = advance (combinational from out_ready and the final valid bit only).
- A beat transfers when in_valid & in_ready. On transfer, stage 0 registers:
  - the SEG-bit sum of segment 0: x[SEG-1:0] + y'[SEG-1:0] + c0, where y' = sub ? ~y : y and c0 = sub ? 1 : cin;
  - the segment carry;
  - the unprocessed upper segments of x and y';
  - the sub flag.
- Stage k (1..STAGES-1), when advance is high, adds segment k of the carried operands plus the carry registered by stage k-1. It forwards the lower result segments unchanged and forwards the remaining operand segments.
- The last stage also captures carry-into-MSB (bit 2*WIDTH-2 carry) for ovf.
- Latency: exactly STAGES cycles from input acceptance to out_valid when not stalled. Throughput is 1 beat/cycle.
- STAGES == 1 degenerates to a single registered full-width add (latency 1).
- Stall: when out_valid & ~out_ready, every stage register and valid bit holds. s, cout and ovf stay stable while out_valid is high and out_ready is low.
- Bubbles: stage valid bits propagate with advance. Empty slots travel through without producing out_valid.
- Simultaneous input accept and output consume in the same cycle is legal: no bubble is inserted and there is no loss.
- Arithmetic wraps modulo 2^(2*WIDTH). Carries never propagate combinationally across a stage boundary.

Optional Feature:
Macro PIPE_RCA_SAT_EN.
- Defined: adds input sat (1 bit, registered with the beat). When sat=1 and ovf would be 1, s is clamped to the signed extreme: 0x7FFF for positive overflow (both operands' effective MSB 0), 0x8000 for negative overflow (WIDTH=8). ovf is still reported as 1. The clamp is applied in the last stage with no extra latency.
- Undefined: no sat port; results always wrap.

Test Plan:
WIDTH=8, STAGES=4: x=0x1234, y=0x0FCD, cin=1, sub=0, out_ready=1 -> after 4 cycles s=0x2202, cout=0, ovf=0.
Carry across all segments: x=0xFFFF, y=0x0001, cin=0 -> s=0x0000, cout=1, ovf=0. Then x=0x7FFF, y=0x0001 -> s=0x8000, ovf=1, cout=0.
Subtract: x=0x0005, y=0x0007, sub=1 -> s=0xFFFE, cout=0 (borrow). Then x=0x8000, y=0x0001, sub=1 -> s=0x7FFF, ovf=1.
Back-pressure: stream 8 beats of x=i, y=0x0100*i; hold out_ready=0 for cycles 6-9 -> in_ready=0 during stall, outputs stable, all 8 results appear in order with none lost or duplicated.
Reset mid-flight: accept 3 beats, drop rst_n for 1 cycle at cycle 2 -> out_valid never rises for those beats, and all outputs read 0 after reset.
With PIPE_RCA_SAT_EN and sat=1: x=0x7FFF, y=0x0001 -> s=0x7FFF, ovf=1. x=0x8000, y=0xFFFF -> s=0x8000, ovf=1.
